// File: rtl/cursor_ctrl.sv
// rtl/cursor_ctrl.sv - setup-mode cursor controller: button sync, wrapping cursor, auto-repeat, toggle pulse, blink
module cursor_ctrl #(
  parameter int ROWS       = 16,
  parameter int COLS       = 16,
  parameter int REPEAT_DLY = 25000000,
  parameter int REPEAT_PER = 5000000,
  parameter int BLINK_PER  = 12500000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     setup,
  input  logic                     btn_up,
  input  logic                     btn_down,
  input  logic                     btn_left,
  input  logic                     btn_right,
  input  logic                     btn_toggle,
  output logic [ROWS-1:0]          row_sel,
  output logic [COLS-1:0]          col_sel,
  output logic [$clog2(ROWS)-1:0]  cur_row,
  output logic [$clog2(COLS)-1:0]  cur_col,
  output logic                     toggle,
  output logic                     blink_on
);

  localparam int RW   = $clog2(ROWS);
  localparam int CLW  = $clog2(COLS);
  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CW   = (RMAX > 2) ? $clog2(RMAX) : 1;
  localparam int BW   = (BLINK_PER > 2) ? $clog2(BLINK_PER) : 1;

  localparam logic [RW-1:0]  ROW_LAST   = RW'(ROWS - 1);
  localparam logic [CLW-1:0] COL_LAST   = CLW'(COLS - 1);
  localparam logic [CW-1:0]  DLY_LOAD   = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0]  PER_LOAD   = CW'(REPEAT_PER - 1);
  localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_PER - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

  // Bit order for every button vector: 0 up, 1 down, 2 left, 3 right, 4 toggle.
  logic [4:0] btn_raw, sync1, sync2, prev, rise;
  logic [3:0] edge_mv, mv, dir;
  logic       rep_fire, tog_req, restart;
  logic [RW-1:0]  row_nx;
  logic [CLW-1:0] col_nx;
  logic [CW-1:0]  cnt;
  logic [BW-1:0]  bcnt;
  rep_state_t     state;

  assign btn_raw = {btn_toggle, btn_right, btn_left, btn_down, btn_up};
  assign rise    = sync2 & ~prev;

  // Flops preset to 1 so a button held through reset needs a fresh press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_comb begin
    edge_mv = '0;
    if (setup && !rise[4]) begin
      edge_mv[0] = rise[0] & ~rise[1];
      edge_mv[1] = rise[1] & ~rise[0];
      edge_mv[2] = rise[2] & ~rise[3];
      edge_mv[3] = rise[3] & ~rise[2];
    end
    rep_fire = setup && !rise[4] && (edge_mv == 4'b0) && (state != IDLE) &&
               (sync2 == {1'b0, dir}) && (cnt == '0);
    mv       = (edge_mv != 4'b0) ? edge_mv : (rep_fire ? dir : 4'b0);
    tog_req  = setup & rise[4];
    restart  = tog_req | (mv != 4'b0);

    row_nx = cur_row;
    if (mv[0])      row_nx = (cur_row == '0) ? ROW_LAST : cur_row - RW'(1);
    else if (mv[1]) row_nx = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);

    col_nx = cur_col;
    if (mv[2])      col_nx = (cur_col == '0) ? COL_LAST : cur_col - CLW'(1);
    else if (mv[3]) col_nx = (cur_col == COL_LAST) ? '0 : cur_col + CLW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_row <= '0;
      cur_col <= '0;
      row_sel <= '0;
      col_sel <= '0;
      toggle  <= 1'b0;
    end else begin
      cur_row <= row_nx;
      cur_col <= col_nx;
      row_sel <= setup ? (ROWS'(1) << row_nx) : '0;
      col_sel <= setup ? (COLS'(1) << col_nx) : '0;
      toggle  <= tog_req;
    end
  end

  // Auto-repeat only arms when the moved direction is the sole button held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      dir   <= '0;
    end else if (!setup) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (edge_mv != 4'b0) begin
      if ($onehot(edge_mv) && (sync2 == {1'b0, edge_mv})) begin
        state <= DELAY;
        dir   <= edge_mv;
        cnt   <= DLY_LOAD;
      end else begin
        state <= IDLE;
      end
    end else begin
      case (state)
        DELAY, REPEAT: begin
          if (sync2 != {1'b0, dir}) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state <= REPEAT;
            cnt   <= PER_LOAD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt     <= '0;
      blink_on <= 1'b1;
    end else if (!setup || restart) begin
      bcnt     <= '0;
      blink_on <= 1'b1;
    end else if (bcnt == BLINK_LAST) begin
      bcnt     <= '0;
      blink_on <= ~blink_on;
    end else begin
      bcnt <= bcnt + BW'(1);
    end
  end

endmodule

// File: tb/tb_cursor_ctrl.sv
// tb/tb_cursor_ctrl.sv - randomized scoreboard bench for cursor_ctrl against an event-level reference model
module tb_cursor_ctrl;

  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int DLY  = 10;
  localparam int PER  = 4;
  localparam int BP   = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic setup = 1'b1;
  logic [4:0] btn = '0;  // 0 up, 1 down, 2 left, 3 right, 4 toggle
  logic [ROWS-1:0] row_sel;
  logic [COLS-1:0] col_sel;
  logic [3:0] cur_row, cur_col;
  logic toggle, blink_on;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dut_moves = 0;
  int dut_toggles = 0;

  typedef struct {int cyc; int row; int col; bit tog;} evt_t;
  evt_t q[$];

  int m_row, m_col, rep_dir, rep_next, blink_ref;
  bit rep, exp_sel_on, exp_blink;
  bit [4:0] h1, h2, h3;

  cursor_ctrl #(.ROWS(ROWS), .COLS(COLS), .REPEAT_DLY(DLY), .REPEAT_PER(PER), .BLINK_PER(BP)) dut (
    .clk(clk), .reset(rst_n), .setup(setup),
    .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]), .btn_toggle(btn[4]),
    .row_sel(row_sel), .col_sel(col_sel), .cur_row(cur_row), .cur_col(cur_col),
    .toggle(toggle), .blink_on(blink_on)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an event at edge n comes from a button first seen at n-2;
  // repeats follow at m+DLY, m+DLY+PER, ... while that direction alone is held.
  initial begin
    m_row = 0; m_col = 0; rep = 0; rep_dir = 0; rep_next = 0; blink_ref = 0;
    exp_sel_on = 0; exp_blink = 1; h1 = '1; h2 = '1; h3 = '1;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_row = 0; m_col = 0; rep = 0; h1 = '1; h2 = '1; h3 = '1;
        blink_ref = cyc; exp_sel_on = 0; exp_blink = 1;
      end else begin
        bit [4:0] rise, held;
        bit tog, moved, started;
        int dv, dh, d;
        rise = h2 & ~h3;
        held = h2;
        tog = 0; moved = 0; started = 0;
        if (!setup) begin
          rep = 0;
          blink_ref = cyc;
        end else if (rise[4]) begin
          tog = 1;
          blink_ref = cyc;
        end else begin
          dv = int'(rise[1]) - int'(rise[0]);
          dh = int'(rise[3]) - int'(rise[2]);
          if (dv != 0 || dh != 0) begin
            m_row = (m_row + dv + ROWS) % ROWS;
            m_col = (m_col + dh + COLS) % COLS;
            moved = 1;
            blink_ref = cyc;
            d = (dv < 0) ? 0 : (dv > 0) ? 1 : (dh < 0) ? 2 : 3;
            if ((dv == 0 || dh == 0) && held == 5'(1 << d)) begin
              rep = 1; rep_dir = d; rep_next = cyc + DLY; started = 1;
            end else begin
              rep = 0;
            end
          end else if (rep && held == 5'(1 << rep_dir) && cyc == rep_next) begin
            case (rep_dir)
              0: m_row = (m_row + ROWS - 1) % ROWS;
              1: m_row = (m_row + 1) % ROWS;
              2: m_col = (m_col + COLS - 1) % COLS;
              default: m_col = (m_col + 1) % COLS;
            endcase
            moved = 1;
            rep_next = cyc + PER;
            blink_ref = cyc;
          end
        end
        if (rep && !started && held != 5'(1 << rep_dir)) rep = 0;
        if (moved || tog) q.push_back('{cyc, m_row, m_col, tog});
        exp_sel_on = setup;
        exp_blink = !setup || (((cyc - blink_ref) / BP) % 2 == 0);
        h3 = h2; h2 = h1; h1 = btn;
      end
    end
  end

  // Monitor: DUT events (toggle pulse or cursor change) are matched against the queue.
  initial begin
    int prev_row, prev_col;
    prev_row = 0; prev_col = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
      end else begin
        bit dut_evt, mod_evt;
        dut_evt = toggle || (int'(cur_row) != prev_row) || (int'(cur_col) != prev_col);
        mod_evt = (q.size() > 0) && (q[0].cyc == cyc);
        if (int'(cur_row) != prev_row || int'(cur_col) != prev_col) dut_moves++;
        if (toggle) dut_toggles++;
        if (dut_evt || mod_evt) begin
          checks++;
          if (dut_evt && mod_evt) begin
            evt_t e;
            e = q.pop_front();
            if (int'(cur_row) != e.row || int'(cur_col) != e.col || toggle != e.tog) begin
              errors++;
              $display("FAIL event@%0d: got row=%0d col=%0d tog=%0b expected row=%0d col=%0d tog=%0b",
                       cyc, cur_row, cur_col, toggle, e.row, e.col, e.tog);
            end
          end else if (dut_evt) begin
            errors++;
            $display("FAIL event@%0d: got unexpected row=%0d col=%0d tog=%0b expected no event",
                     cyc, cur_row, cur_col, toggle);
          end else begin
            evt_t e;
            e = q.pop_front();
            errors++;
            $display("FAIL event@%0d: got no event expected row=%0d col=%0d tog=%0b", cyc, e.row, e.col, e.tog);
          end
        end
        check("row_sel", 32'(row_sel), exp_sel_on ? 32'(1 << m_row) : 32'd0);
        check("col_sel", 32'(col_sel), exp_sel_on ? 32'(1 << m_col) : 32'd0);
        check("blink_on", 32'(blink_on), 32'(exp_blink));
      end
      prev_row = int'(cur_row);
      prev_col = int'(cur_col);
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input logic [4:0] mask, input int n);
    btn = mask;
    step(n);
    btn = '0;
  endtask

  task automatic idle(input int n);
    btn = '0;
    step(n);
  endtask

  initial begin
    int m0, t0;
    step(3);
    rst_n = 1'b1;
    idle(100);
    check("reset row_sel", 32'(row_sel), 32'h0001);
    check("reset col_sel", 32'(col_sel), 32'h0001);
    check("reset cur_row", 32'(cur_row), 32'd0);
    check("idle toggles", 32'(dut_toggles), 32'd0);

    press(5'b00001, 3); idle(5);
    check("up wrap cur_row", 32'(cur_row), 32'd15);
    check("up wrap row_sel", 32'(row_sel), 32'h8000);

    press(5'b00100, 2); idle(5);
    check("left wrap cur_col", 32'(cur_col), 32'd15);
    for (int i = 0; i < 4; i++) begin
      press(5'b01000, 3); idle(4);
      check("right step cur_col", 32'(cur_col), 32'(i));
    end
    press(5'b01000, 3); idle(4);
    press(5'b01000, 3); idle(4);
    check("right to 5", 32'(cur_col), 32'd5);

    m0 = dut_moves;
    press(5'b00010, 40); idle(20);
    check("repeat move count", 32'(dut_moves - m0), 32'd9);
    check("repeat cur_row", 32'(cur_row), 32'd8);

    t0 = dut_toggles;
    press(5'b10100, 3); idle(5);
    check("toggle pulses", 32'(dut_toggles - t0), 32'd1);
    check("toggle keeps col", 32'(cur_col), 32'd5);

    press(5'b00011, 3); idle(5);
    check("up+down row", 32'(cur_row), 32'd8);

    t0 = dut_toggles;
    setup = 1'b0;
    press(5'b11000, 3); idle(3);
    check("setup0 row_sel", 32'(row_sel), 32'd0);
    check("setup0 col_sel", 32'(col_sel), 32'd0);
    check("setup0 cur_col", 32'(cur_col), 32'd5);
    check("setup0 toggles", 32'(dut_toggles - t0), 32'd0);
    setup = 1'b1;
    idle(3);
    check("setup1 col_sel", 32'(col_sel), 32'h0020);
    check("setup1 row_sel", 32'(row_sel), 32'h0100);

    btn = 5'b00100;
    step(5);
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(20);
    check("held reset cur_col", 32'(cur_col), 32'd0);
    check("held reset cur_row", 32'(cur_row), 32'd0);
    idle(5);
    press(5'b00100, 3); idle(5);
    check("repress left", 32'(cur_col), 32'd15);

    for (int it = 0; it < 150; it++) begin
      logic [4:0] mask;
      if ($urandom_range(0, 9) < 6) mask = 5'(1 << $urandom_range(0, 3));
      else mask = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 19) == 0) setup = ~setup;
      press(mask, $urandom_range(1, 30));
      idle($urandom_range(0, 6));
    end
    setup = 1'b1;
    idle(10);
    check("queue drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
